aes_arbiter: RTL and testbench

- Shares one AES-128 encrypt engine (aes) and one decrypt engine (invAes) between NUM_REQ requesters, for example the exalu core path and a DMA/crypto-offload port.
- Accepts one request at a time with a valid/ready handshake, using round-robin priority.
- Sequences the engine's one-cycle write-enable and waits out its busy flag.
- Captures the 128-bit result and returns it to the granted requester with a valid/ready response handshake.

---
 rtl/aes_arb_pkg.sv | 19 +
 rtl/aes_arbiter_if.sv | 43 ++++
 rtl/aes_arbiter_rr_pick.sv | 27 ++
 rtl/aes_arbiter.sv | 165 ++++++++++++++++
 tb/tb_aes_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_arb_pkg.sv
// aes_arb_pkg: shared types and constants for the AES engine arbiter and its helpers.
package aes_arb_pkg;

   localparam int AES_BLK_W = 128;

   typedef enum logic [2:0] {
      IDLE,
      LAUNCH,
      SETTLE,
      WAIT,
      RESP
   } arbState_t;

   typedef enum logic {
      OP_ENC,
      OP_DEC
   } aesOp_t;

endpackage

// File: rtl/aes_arbiter_if.sv
// aes_arbiter_if: requester request/response handshakes plus the engine-facing
// start/operand/busy/result bus of the AES arbiter.
// The slave modport is the arbiter's view; master is the requester/engine side.
interface aes_arbiter_if #(
   parameter int NUM_REQ = 2
);
   // Requester side
   logic [NUM_REQ-1:0]                          reqValid;
   logic [NUM_REQ-1:0]                          reqReady;
   logic [NUM_REQ-1:0]                          reqDecrypt;
   logic [NUM_REQ*aes_arb_pkg::AES_BLK_W-1:0]   reqText;
   logic [NUM_REQ*aes_arb_pkg::AES_BLK_W-1:0]   reqKey;
   logic [NUM_REQ-1:0]                          rspValid;
   logic [NUM_REQ-1:0]                          rspReady;
   logic [aes_arb_pkg::AES_BLK_W-1:0]           rspData;
   logic                                        rspErr;
   // Engine side
   logic                                        encWE;
   logic                                        decWE;
   logic [aes_arb_pkg::AES_BLK_W-1:0]           engText;
   logic [aes_arb_pkg::AES_BLK_W-1:0]           engKey;
   logic                                        encBusy;
   logic                                        decBusy;
   logic [aes_arb_pkg::AES_BLK_W-1:0]           encOut;
   logic [aes_arb_pkg::AES_BLK_W-1:0]           decOut;
   // Status
   logic                                        busy;

   modport slave (
      input  reqValid, reqDecrypt, reqText, reqKey, rspReady,
      input  encBusy, decBusy, encOut, decOut,
      output reqReady, rspValid, rspData, rspErr,
      output encWE, decWE, engText, engKey, busy
   );

   modport master (
      output reqValid, reqDecrypt, reqText, reqKey, rspReady,
      output encBusy, decBusy, encOut, decOut,
      input  reqReady, rspValid, rspData, rspErr,
      input  encWE, decWE, engText, engKey, busy
   );

endinterface

// File: rtl/aes_arbiter_rr_pick.sv
// rr_pick: combinational round-robin search. Returns the first set request bit
// at or above rrPtr, wrapping modulo N, and whether any bit was set at all.
module rr_pick #(
   parameter int N     = 2,
   parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     reqValid,
   input  logic [PTR_W-1:0] rrPtr,
   output logic [PTR_W-1:0] grantIdx,
   output logic             anyValid
);

   // Scan offsets from farthest to nearest so the nearest set bit wins.
   always_comb begin
      // NOTE: every combinational output gets a default first; a path that
      // leaves one unassigned would infer a latch.
      grantIdx = '0;
      anyValid = 1'b0;
      for (int k = N - 1; k >= 0; k--) begin
         if (reqValid[(int'(rrPtr) + k) % N]) begin
            grantIdx = PTR_W'((int'(rrPtr) + k) % N);
            anyValid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/aes_arbiter.sv
// aes_arbiter: shares one AES-128 encrypt engine and one decrypt engine between
// NUM_REQ requesters with round-robin grant, one-cycle engine start pulse,
// busy wait and a held response handshake.
// Build macro AES_ARB_TIMEOUT_EN: bounds WAIT to TIMEOUT_CYCLES and returns an
// error response (rspErr=1, rspData=0) when the engine never finishes.
module aes_arbiter
   import aes_arb_pkg::*;
#(
   parameter int NUM_REQ        = 2,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic         clock,
   input  logic         resetN,
   aes_arbiter_if.slave bus
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   // Reject configurations outside the supported range at elaboration.
   if (NUM_REQ < 1 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
      $error("aes_arbiter: unsupported NUM_REQ or TIMEOUT_CYCLES");
   end

   arbState_t            state_q, state_d;
   logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
   logic [PTR_W-1:0]     grant_q, grant_d;
   aesOp_t               op_q, op_d;
   logic [AES_BLK_W-1:0] text_q, text_d;
   logic [AES_BLK_W-1:0] key_q, key_d;
   logic [AES_BLK_W-1:0] rsp_data_q, rsp_data_d;
   logic [PTR_W-1:0]     pick_idx;
   logic                 any_valid;
   logic                 sel_busy;

`ifdef AES_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0]     tmo_cnt_q, tmo_cnt_d;
   logic                 rsp_err_q, rsp_err_d;
`endif

   rr_pick #(
      .N     (NUM_REQ),
      .PTR_W (PTR_W)
   ) u_rr_pick (
      .reqValid (bus.reqValid),
      .rrPtr    (rr_ptr_q),
      .grantIdx (pick_idx),
      .anyValid (any_valid)
   );

   // Only the busy flag of the engine that owns the current operation matters.
   assign sel_busy = (op_q == OP_DEC) ? bus.decBusy : bus.encBusy;

   // Next-state and operand/result register updates for the transaction FSM.
   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      grant_d    = grant_q;
      op_d       = op_q;
      text_d     = text_q;
      key_d      = key_q;
      rsp_data_d = rsp_data_q;
`ifdef AES_ARB_TIMEOUT_EN
      tmo_cnt_d  = tmo_cnt_q;
      rsp_err_d  = rsp_err_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (any_valid) begin
               grant_d = pick_idx;
               op_d    = bus.reqDecrypt[pick_idx] ? OP_DEC : OP_ENC;
               text_d  = bus.reqText[int'(pick_idx)*AES_BLK_W +: AES_BLK_W];
               key_d   = bus.reqKey[int'(pick_idx)*AES_BLK_W +: AES_BLK_W];
               state_d = LAUNCH;
            end
         end
         LAUNCH: state_d = SETTLE;
         SETTLE: begin
            // The engine raises busy one cycle after its start pulse, so the
            // flag is not trusted until WAIT.
            state_d = WAIT;
`ifdef AES_ARB_TIMEOUT_EN
            tmo_cnt_d = '0;
`endif
         end
         WAIT: begin
            if (!sel_busy) begin
               rsp_data_d = (op_q == OP_DEC) ? bus.decOut : bus.encOut;
               state_d    = RESP;
`ifdef AES_ARB_TIMEOUT_EN
               rsp_err_d  = 1'b0;
            end else begin
               tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
               if (tmo_cnt_d == CNT_W'(TIMEOUT_CYCLES)) begin
                  rsp_data_d = '0;
                  rsp_err_d  = 1'b1;
                  state_d    = RESP;
               end
`endif
            end
         end
         RESP: begin
            if (bus.rspReady[grant_q]) begin
               rr_ptr_d = PTR_W'((int'(grant_q) + 1) % NUM_REQ);
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers; reset abandons any in-flight operation.
   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         // NOTE: operand and result registers are reset too, because
         // engText, engKey and rspData must read zero while in reset.
         state_q    <= IDLE;
         rr_ptr_q   <= '0;
         grant_q    <= '0;
         op_q       <= OP_ENC;
         text_q     <= '0;
         key_q      <= '0;
         rsp_data_q <= '0;
`ifdef AES_ARB_TIMEOUT_EN
         tmo_cnt_q  <= '0;
         rsp_err_q  <= 1'b0;
`endif
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge values, independent of statement order.
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         grant_q    <= grant_d;
         op_q       <= op_d;
         text_q     <= text_d;
         key_q      <= key_d;
         rsp_data_q <= rsp_data_d;
`ifdef AES_ARB_TIMEOUT_EN
         tmo_cnt_q  <= tmo_cnt_d;
         rsp_err_q  <= rsp_err_d;
`endif
      end
   end

   // One-hot handshake outputs: grant only from IDLE, response only from RESP.
   always_comb begin
      bus.reqReady = '0;
      bus.rspValid = '0;
      if (state_q == IDLE && any_valid) bus.reqReady[pick_idx] = 1'b1;
      if (state_q == RESP)              bus.rspValid[grant_q]  = 1'b1;
   end

   assign bus.encWE   = (state_q == LAUNCH) && (op_q == OP_ENC);
   assign bus.decWE   = (state_q == LAUNCH) && (op_q == OP_DEC);
   assign bus.engText = text_q;
   assign bus.engKey  = key_q;
   assign bus.rspData = rsp_data_q;
   assign bus.busy    = (state_q != IDLE);
`ifdef AES_ARB_TIMEOUT_EN
   assign bus.rspErr  = rsp_err_q;
`else
   assign bus.rspErr  = 1'b0;
`endif

endmodule

// File: tb/tb_aes_arbiter.sv
// tb_aes_arbiter: directed bench for aes_arbiter with two requesters, engine
// stubs and a transaction-level reference model checked every cycle.
module tb_aes_arbiter;

   localparam int NREQ    = 2;
   localparam int TMO_CYC = 8;

   localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

   logic clock  = 1'b0;
   logic resetN = 1'b1;

   aes_arbiter_if #(.NUM_REQ(NREQ)) bus ();

   aes_arbiter #(
      .NUM_REQ        (NREQ),
      .TIMEOUT_CYCLES (TMO_CYC)
   ) dut (
      .clock  (clock),
      .resetN (resetN),
      .bus    (bus.slave)
   );

   initial forever #5 clock = ~clock;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Engine behaviour: FIPS-197 C.1 vector both ways, otherwise a simple mix.
   function automatic logic [127:0] eng_fn(input logic dec, input logic [127:0] t, input logic [127:0] k);
      if (!dec && t == PT && k == KEY) return CT;
      if (dec && t == CT && k == KEY)  return PT;
      return dec ? ~(t ^ k) : (t ^ {k[63:0], k[127:64]});
   endfunction

   // ---------------- engine stubs ----------------
   int   busy_len = 2;
   bit   hang_enc = 1'b0;

   logic         enc_busy = 1'b0, enc_pend = 1'b0;
   logic [127:0] enc_out = '0, enc_res = '0;
   int           enc_cnt = 0;
   logic         dec_busy = 1'b0, dec_pend = 1'b0;
   logic [127:0] dec_out = '0, dec_res = '0;
   int           dec_cnt = 0;

   assign bus.encBusy = enc_busy;
   assign bus.encOut  = enc_out;
   assign bus.decBusy = dec_busy;
   assign bus.decOut  = dec_out;

   // Busy rises one edge after the start pulse and stays high busy_len cycles.
   always @(posedge clock) begin
      if (enc_pend) begin
         enc_busy <= 1'b1; enc_cnt <= busy_len; enc_pend <= 1'b0;
      end else if (enc_busy && !hang_enc) begin
         if (enc_cnt <= 1) begin enc_busy <= 1'b0; enc_out <= enc_res; end
         else enc_cnt <= enc_cnt - 1;
      end
      if (bus.encWE) begin enc_pend <= 1'b1; enc_res <= eng_fn(1'b0, bus.engText, bus.engKey); end
   end

   always @(posedge clock) begin
      if (dec_pend) begin
         dec_busy <= 1'b1; dec_cnt <= busy_len; dec_pend <= 1'b0;
      end else if (dec_busy) begin
         if (dec_cnt <= 1) begin dec_busy <= 1'b0; dec_out <= dec_res; end
         else dec_cnt <= dec_cnt - 1;
      end
      if (bus.decWE) begin dec_pend <= 1'b1; dec_res <= eng_fn(1'b1, bus.engText, bus.engKey); end
   end

   // ---------------- reference model + compare ----------------
   bit           m_busy = 1'b0;
   int           m_ptr  = 0;
   int           m_g    = 0;
   bit           m_dec  = 1'b0;
   bit           m_tmo  = 1'b0;
   logic [127:0] m_text = '0, m_key = '0;
   int           m_gc   = 0;
   int           m_rc   = 0;
   int           grant_log[$];
   int           last_grant_cyc = 0, last_done_cyc = 0;
   int           enc_pulses = 0, dec_pulses = 0, max_pop = 0;

   // A transaction owns the engines from grant to response acceptance. The
   // response appears after LAUNCH, SETTLE and the WAIT cycles (busy_len busy
   // cycles plus the one where busy is seen low): grant cycle + 4 + busy_len.
   always @(negedge clock) begin
      logic [NREQ-1:0]  exp_ready, exp_rsp;
      logic [127:0]     exp_data;
      int               g;
      if (!resetN) begin
         m_busy = 1'b0;
         m_ptr  = 0;
      end else begin
         exp_ready = '0;
         g = -1;
         if (!m_busy) begin
            for (int k = 0; k < NREQ; k++) begin
               if (bus.reqValid[(m_ptr + k) % NREQ]) begin g = (m_ptr + k) % NREQ; break; end
            end
            if (g >= 0) exp_ready[g] = 1'b1;
         end
         exp_rsp = '0;
         if (m_busy && cyc >= m_rc) exp_rsp[m_g] = 1'b1;

         check("reqReady", bus.reqReady, exp_ready);
         check("encWE", bus.encWE, m_busy && cyc == m_gc + 1 && !m_dec);
         check("decWE", bus.decWE, m_busy && cyc == m_gc + 1 && m_dec);
         check("busy", bus.busy, m_busy);
         check("rspValid", bus.rspValid, exp_rsp);
         if (m_busy) begin
            check("engText", bus.engText, m_text);
            check("engKey", bus.engKey, m_key);
         end
         if (exp_rsp != '0) begin
            exp_data = m_tmo ? 128'h0 : eng_fn(m_dec, m_text, m_key);
            check("rspData", bus.rspData, exp_data);
            check("rspErr", bus.rspErr, m_tmo);
         end

         if (bus.encWE) enc_pulses++;
         if (bus.decWE) dec_pulses++;
         if ($countones(bus.reqReady) > max_pop) max_pop = $countones(bus.reqReady);

         if (g >= 0) begin
            m_busy = 1'b1;
            m_g    = g;
            m_dec  = bus.reqDecrypt[g];
            m_text = bus.reqText[g*128 +: 128];
            m_key  = bus.reqKey[g*128 +: 128];
            m_gc   = cyc;
            m_tmo  = 1'b0;
            last_grant_cyc = cyc;
            grant_log.push_back(g);
            if (hang_enc && !m_dec) begin
`ifdef AES_ARB_TIMEOUT_EN
               m_rc  = cyc + 3 + TMO_CYC;
               m_tmo = 1'b1;
`else
               m_rc  = 32'h3fff_ffff;
`endif
            end else begin
               m_rc = cyc + 4 + busy_len;
            end
         end else if (exp_rsp != '0 && bus.rspReady[m_g]) begin
            m_busy = 1'b0;
            m_ptr  = (m_g + 1) % NREQ;
            last_done_cyc = cyc;
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic wait_grant(input int idx, output int gc);
      bit got = 1'b0;
      gc = -1;
      for (int c = 0; c < 100 && !got; c++) begin
         @(negedge clock);
         if (bus.reqReady[idx]) begin got = 1'b1; gc = cyc; end
      end
      check("grant_seen", got, 1'b1);
      @(posedge clock); #1;
      bus.reqValid[idx] = 1'b0;
   endtask

   task automatic send(input int idx, input logic dec, input logic [127:0] t,
                       input logic [127:0] k, output int gc);
      bus.reqDecrypt[idx]        = dec;
      bus.reqText[idx*128 +: 128] = t;
      bus.reqKey[idx*128 +: 128]  = k;
      bus.reqValid[idx]          = 1'b1;
      wait_grant(idx, gc);
   endtask

   task automatic wait_rsp(input int idx, output int rc);
      bit got = 1'b0;
      rc = -1;
      for (int c = 0; c < 100 && !got; c++) begin
         @(negedge clock);
         if (bus.rspValid[idx]) begin got = 1'b1; rc = cyc; end
      end
      check("rsp_seen", got, 1'b1);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"}, bus.busy, 1'b0);
      check({tag, "_reqReady"}, bus.reqReady, '0);
      check({tag, "_rspValid"}, bus.rspValid, '0);
      check({tag, "_we"}, {bus.encWE, bus.decWE}, 2'b00);
      check({tag, "_engText"}, bus.engText, '0);
      check({tag, "_engKey"}, bus.engKey, '0);
      check({tag, "_rspData"}, bus.rspData, '0);
      check({tag, "_rspErr"}, bus.rspErr, 1'b0);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int gc, rc;
      bit seen;
      logic [127:0] held;
      int exp_order [4] = '{0, 1, 0, 1};

      bus.reqValid   = '0;
      bus.reqDecrypt = '0;
      bus.reqText    = '0;
      bus.reqKey     = '0;
      bus.rspReady   = '1;

      #1 resetN = 1'b0;
      #1 check_all_zero("reset");
      repeat (2) @(posedge clock);
      #1 resetN = 1'b1;

      // Single encrypt on requester 0.
      enc_pulses = 0; dec_pulses = 0; busy_len = 2;
      send(0, 1'b0, PT, KEY, gc);
      wait_rsp(0, rc);
      check("enc_latency", rc - gc, 6);
      check("enc_data", bus.rspData, CT);
      check("enc_pulses", enc_pulses, 1);
      check("enc_no_dec", dec_pulses, 0);
      repeat (3) @(posedge clock); #1;

      // Single decrypt on requester 1.
      enc_pulses = 0; dec_pulses = 0;
      send(1, 1'b1, CT, KEY, gc);
      wait_rsp(1, rc);
      check("dec_data", bus.rspData, PT);
      check("dec_pulses", dec_pulses, 1);
      check("dec_no_enc", enc_pulses, 0);
      repeat (3) @(posedge clock); #1;

      // Fairness: both requesters valid continuously.
      grant_log.delete();
      max_pop = 0;
      bus.reqDecrypt = 2'b10;
      bus.reqText    = {128'hfeedface_0000_1111_2222_3333_4444_5555, 128'h0123_4567_89ab_cdef_0f1e_2d3c_4b5a_6978};
      bus.reqKey     = {KEY, ~KEY};
      bus.reqValid   = 2'b11;
      for (int c = 0; c < 300 && grant_log.size() < 4; c++) begin
         @(posedge clock); #1;
      end
      bus.reqValid = '0;
      check("fair_count", grant_log.size(), 4);
      for (int i = 0; i < 4; i++) check("fair_order", grant_log[i], exp_order[i]);
      check("ready_onehot", max_pop, 1);
      repeat (15) @(posedge clock); #1;

      // Response backpressure with a pending competing request.
      bus.rspReady = '0;
      send(0, 1'b0, 128'h0badc0de_0badc0de_0badc0de_0badc0de, KEY, gc);
      bus.reqDecrypt[1]         = 1'b1;
      bus.reqText[128 +: 128]   = 128'h5555aaaa_5555aaaa_5555aaaa_5555aaaa;
      bus.reqValid[1]           = 1'b1;
      wait_rsp(0, rc);
      held = bus.rspData;
      @(posedge clock); #1;
      bus.rspReady = 2'b10;
      repeat (10) begin
         @(negedge clock);
         check("bp_valid", bus.rspValid, 2'b01);
         check("bp_data", bus.rspData, held);
         check("bp_no_grant", bus.reqReady, 2'b00);
      end
      @(posedge clock); #1;
      bus.rspReady = 2'b11;
      wait_grant(1, gc);
      check("bp_regrant", last_grant_cyc - last_done_cyc, 1);
      wait_rsp(1, rc);
      repeat (3) @(posedge clock); #1;

      // Reset pulsed while WAIT sees the engine busy.
      busy_len = 6;
      send(0, 1'b0, PT, KEY, gc);
      repeat (4) @(posedge clock); #1;
      check("pre_reset_busy", bus.busy, 1'b1);
      resetN = 1'b0;
      #1 check_all_zero("midrst");
      repeat (2) @(posedge clock);
      #1 resetN = 1'b1;
      seen = 1'b0;
      repeat (20) begin
         @(negedge clock);
         if (bus.rspValid != '0) seen = 1'b1;
      end
      check("abort_no_rsp", seen, 1'b0);
      @(posedge clock); #1;

      // Encrypt engine never finishes.
      busy_len = 2;
      hang_enc = 1'b1;
      send(0, 1'b0, PT, KEY, gc);
`ifdef AES_ARB_TIMEOUT_EN
      wait_rsp(0, rc);
      check("tmo_latency", rc - gc, 3 + TMO_CYC);
      check("tmo_err", bus.rspErr, 1'b1);
      check("tmo_data", bus.rspData, '0);
`else
      seen = 1'b0;
      repeat (40) begin
         @(negedge clock);
         if (bus.rspValid != '0) seen = 1'b1;
      end
      check("hang_no_rsp", seen, 1'b0);
      check("hang_busy", bus.busy, 1'b1);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
